pixel_clock_tx: RTL and testbench

// - Transmit end of the x6 pixel-clock scheme. Runs in the 81.000 MHz pixelClockX6 domain and regenerates a
//   13.500 MHz pixel clock, pixelClockOut, with 3 cycles high and 3 cycles low.
// - Launches one buffered pixel, with hsync/vsync, per output clock period.
// - Pixels enter through a valid/ready FIFO. Data is launched on the falling edge of pixelClockOut, so the

---
 rtl/pixel_clock_tx_pkg.sv | 22 ++
 rtl/pixel_tx_fifo.sv | 67 ++++++
 rtl/pixel_clock_tx.sv | 142 ++++++++++++++
 tb/tb_pixel_clock_tx.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_clock_tx_pkg.sv
// Shared constants, state encoding and phase helper for the x6 pixel-clock transmitter.
package pixel_clock_tx_pkg;

    localparam int PIXEL_PHASES        = 6;
    localparam int PHASE_LAUNCH        = 2;
    localparam int PHASE_CLK_HIGH_LAST = 2;

    localparam logic [2:0] PHASE_LAST_P     = 3'(PIXEL_PHASES - 1);
    localparam logic [2:0] PHASE_LAUNCH_P   = 3'(PHASE_LAUNCH);
    localparam logic [2:0] PHASE_HIGH_END_P = 3'(PHASE_CLK_HIGH_LAST);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } tx_state_e;

    function automatic logic [2:0] next_phase(input logic [2:0] p);
        return (p == PHASE_LAST_P) ? 3'd0 : p + 3'd1;
    endfunction

endpackage

// File: rtl/pixel_tx_fifo.sv
// Small synchronous FIFO with async reset; exposes fill so the transmitter can prime to half depth.
module pixel_tx_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     fill
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      fill_q, fill_d;
    logic             push_ok, pop_ok;

    assign full    = (fill_q == (AW+1)'(DEPTH));
    assign empty   = (fill_q == '0);
    assign fill    = fill_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        // Pointers wrap naturally because DEPTH is a power of two.
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + (AW+1)'(1);
            2'b01:   fill_d = fill_q - (AW+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

endmodule

// File: rtl/pixel_clock_tx.sv
// Regenerates a 3-high/3-low pixel clock from the x6 system clock and launches one buffered pixel
// per period on the falling edge, giving the receiver three system clocks of setup and hold.
module pixel_clock_tx
    import pixel_clock_tx_pkg::*;
#(
    parameter int                    DATA_WIDTH = 16,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_DATA  = '0
) (
    input  logic                  pixelClockX6,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] pixelIn_data,
    input  logic                  pixelIn_hsync,
    input  logic                  pixelIn_vsync,
    input  logic                  pixelIn_valid,
    output logic                  pixelIn_ready,
    output logic                  pixelClockOut,
    output logic [DATA_WIDTH-1:0] pixelDataOut,
    output logic                  hsyncOut,
    output logic                  vsyncOut,
    output logic [2:0]            pixelClockPhase,
    output logic                  streaming,
    output logic                  underflow,
    input  logic                  underflowClear
);

    localparam int FW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FW-1:0] PRIME_FILL = FW'(FIFO_DEPTH / 2);

    logic [2:0]            phase_q, phase_d;
    logic                  clk_out_q, clk_out_d;
    tx_state_e             state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  hsync_q, hsync_d;
    logic                  vsync_q, vsync_d;
    logic                  streaming_q, streaming_d;
    logic                  underflow_q, underflow_d;

    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [FW-1:0]         fifo_fill;
    logic [DATA_WIDTH+1:0] fifo_head;
    logic                  launch, uf_set;

    assign pixelIn_ready = !fifo_full;
    assign fifo_push     = pixelIn_valid && !fifo_full;

    pixel_tx_fifo #(
        .WIDTH (DATA_WIDTH + 2),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (pixelClockX6),
        .rst   (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata ({pixelIn_hsync, pixelIn_vsync, pixelIn_data}),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .fill  (fifo_fill)
    );

    // Clock output is derived from the next phase so it is high exactly while p is 0..2.
    always_comb begin
        phase_d   = next_phase(phase_q);
        clk_out_d = (phase_d <= PHASE_HIGH_END_P);
        launch    = (phase_q == PHASE_LAUNCH_P);
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        hsync_d  = hsync_q;
        vsync_d  = vsync_q;
        fifo_pop = 1'b0;
        uf_set   = 1'b0;
        if (launch) begin
            data_d  = IDLE_DATA;
            hsync_d = 1'b0;
            vsync_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (enable) state_d = ST_PRIME;
                end
                ST_PRIME: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (fifo_fill >= PRIME_FILL) begin
                        state_d  = ST_RUN;
                        fifo_pop = 1'b1;
                        {hsync_d, vsync_d, data_d} = fifo_head;
                    end
                end
                ST_RUN: begin
                    if (!enable) begin
                        state_d = ST_IDLE;
                    end else if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        {hsync_d, vsync_d, data_d} = fifo_head;
                    end else begin
                        uf_set = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        streaming_d = (state_d == ST_RUN);
        // Setting wins over a clear arriving on the same edge.
        underflow_d = uf_set || (underflow_q && !underflowClear);
    end

    always_ff @(posedge pixelClockX6 or posedge reset) begin
        if (reset) begin
            phase_q     <= 3'd0;
            clk_out_q   <= 1'b1;
            state_q     <= ST_IDLE;
            data_q      <= IDLE_DATA;
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            streaming_q <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            phase_q     <= phase_d;
            clk_out_q   <= clk_out_d;
            state_q     <= state_d;
            data_q      <= data_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            streaming_q <= streaming_d;
            underflow_q <= underflow_d;
        end
    end

    assign pixelClockPhase = phase_q;
    assign pixelClockOut   = clk_out_q;
    assign pixelDataOut    = data_q;
    assign hsyncOut        = hsync_q;
    assign vsyncOut        = vsync_q;
    assign streaming       = streaming_q;
    assign underflow       = underflow_q;

endmodule

// File: tb/tb_pixel_clock_tx.sv
// Self-checking bench for pixel_clock_tx: phase table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_pixel_clock_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [15:0] in_data;
    logic        in_hs, in_vs, in_valid, in_ready;
    logic        clk_out;
    logic [15:0] data_out;
    logic        hs_out, vs_out;
    logic [2:0]  phase;
    logic        strm, uf, uf_clr;

    int n_err = 0;
    int n_chk = 0;

    always #6 clk = ~clk;

    pixel_clock_tx dut (
        .pixelClockX6    (clk),
        .reset           (rst),
        .enable          (enable),
        .pixelIn_data    (in_data),
        .pixelIn_hsync   (in_hs),
        .pixelIn_vsync   (in_vs),
        .pixelIn_valid   (in_valid),
        .pixelIn_ready   (in_ready),
        .pixelClockOut   (clk_out),
        .pixelDataOut    (data_out),
        .hsyncOut        (hs_out),
        .vsyncOut        (vs_out),
        .pixelClockPhase (phase),
        .streaming       (strm),
        .underflow       (uf),
        .underflowClear  (uf_clr)
    );

    // Reference model: cycle count modulo 6, a word queue and a mode number (0 idle, 1 prime, 2 run).
    int          m_p;
    int          m_mode;
    bit          m_uf;
    logic [15:0] m_data;
    bit          m_hs, m_vs;
    logic [17:0] m_q[$];

    typedef struct {
        logic       en;
        logic [2:0] exp_phase;
        logic       exp_clk;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_p = 0; m_mode = 0; m_uf = 0; m_data = 16'h0; m_hs = 0; m_vs = 0;
        m_q.delete();
    endtask

    task automatic idle_out();
        m_data = 16'h0; m_hs = 0; m_vs = 0;
    endtask

    task automatic take_head();
        logic [17:0] w;
        w = m_q.pop_front();
        {m_hs, m_vs, m_data} = w;
    endtask

    task automatic cmp_model();
        chk("phase", 32'(phase), 32'(m_p));
        chk("pclk", 32'(clk_out), 32'(m_p < 3));
        chk("data", 32'(data_out), 32'(m_data));
        chk("hsync", 32'(hs_out), 32'(m_hs));
        chk("vsync", 32'(vs_out), 32'(m_vs));
        chk("streaming", 32'(strm), 32'(m_mode == 2));
        chk("underflow", 32'(uf), 32'(m_uf));
        chk("ready", 32'(in_ready), 32'(m_q.size() < 4));
    endtask

    // Advance one system clock: model consumes the inputs present before the edge, then compare.
    task automatic tick();
        bit push, set;
        push = in_valid && (m_q.size() < 4);
        set  = 0;
        if (m_p == 2) begin
            idle_out();
            if (m_mode == 0) begin
                if (enable) m_mode = 1;
            end else if (!enable) begin
                m_mode = 0;
            end else if (m_mode == 1) begin
                if (m_q.size() >= 2) begin m_mode = 2; take_head(); end
            end else begin
                if (m_q.size() > 0) take_head();
                else set = 1;
            end
        end
        if (push) m_q.push_back({in_hs, in_vs, in_data});
        m_uf = set ? 1'b1 : (uf_clr ? 1'b0 : m_uf);
        m_p  = (m_p + 1) % 6;
        @(posedge clk);
        #1;
        cmp_model();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst = 1; enable = 0; in_valid = 0; in_data = 0; in_hs = 0; in_vs = 0; uf_clr = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
    endtask

    initial begin
        int cnt, bad, k;
        bit seen;
        tbl[0] = '{1'b0, 3'd0, 1'b1};
        tbl[1] = '{1'b0, 3'd1, 1'b1};
        tbl[2] = '{1'b0, 3'd2, 1'b1};
        tbl[3] = '{1'b0, 3'd3, 1'b0};
        tbl[4] = '{1'b0, 3'd4, 1'b0};
        tbl[5] = '{1'b0, 3'd5, 1'b0};

        rst = 1; enable = 0; in_valid = 0; in_data = 0; in_hs = 0; in_vs = 0; uf_clr = 0;
        #3;
        chk("rst_phase", 32'(phase), 0);
        chk("rst_pclk", 32'(clk_out), 1);
        chk("rst_data", 32'(data_out), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_strm", 32'(strm), 0);
        chk("rst_uf", 32'(uf), 0);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();

        // Free-running phase and clock pattern with streaming disabled.
        for (int i = 1; i <= 60; i++) begin
            enable = tbl[i % 6].en;
            tick();
            chk("t1_phase", 32'(phase), 32'(tbl[i % 6].exp_phase));
            chk("t1_pclk", 32'(clk_out), 32'(tbl[i % 6].exp_clk));
            chk("t1_data", 32'(data_out), 0);
        end

        // Three words back to back: priming, in-order launch at p=3, 6-clock hold.
        do_reset();
        enable = 1; in_valid = 1;
        in_data = 16'h1111; tick();
        in_data = 16'h2222; tick();
        in_data = 16'h3333; tick();
        in_valid = 0;
        run(5);
        chk("t2_pre_run", 32'(strm), 0);
        tick();
        chk("t2_w1", 32'(data_out), 32'h1111);
        chk("t2_w1_phase", 32'(phase), 3);
        chk("t2_run", 32'(strm), 1);
        run(5);
        chk("t2_w1_hold", 32'(data_out), 32'h1111);
        tick();
        chk("t2_w2", 32'(data_out), 32'h2222);
        run(6);
        chk("t2_w3", 32'(data_out), 32'h3333);
        run(5);

        // Underflow: clear on the setting edge is overridden, one clock later it works.
        uf_clr = 1;
        tick();
        chk("t4_uf_set", 32'(uf), 1);
        chk("t4_idle", 32'(data_out), 0);
        tick();
        chk("t4_uf_clr", 32'(uf), 0);
        uf_clr = 0;

        // hsync rides with exactly one word.
        in_valid = 1; in_data = 16'h00A0; in_hs = 1;
        tick();
        in_valid = 0; in_hs = 0; in_data = 0;
        cnt = 0; bad = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (hs_out) begin
                cnt++;
                if (data_out != 16'h00A0) bad++;
            end
        end
        chk("t5_hs_len", 32'(cnt), 6);
        chk("t5_hs_word", 32'(bad), 0);

        // Back-pressure: four pushes fill the FIFO, the fifth is held off.
        do_reset();
        in_valid = 1;
        for (int i = 0; i < 4; i++) begin
            in_data = 16'h0100 + 16'(i);
            tick();
        end
        chk("t3_full", 32'(in_ready), 0);
        in_data = 16'h0104;
        run(3);
        chk("t3_held", 32'(in_ready), 0);
        enable = 1;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = strm;
        end
        chk("t3_run_reached", 32'(seen), 1);
        chk("t3_ready_back", 32'(in_ready), 1);
        chk("t3_first", 32'(data_out), 32'h0100);
        tick();
        in_valid = 0;
        run(30);

        // Reset at p=4 in RUN with three words buffered.
        do_reset();
        enable = 1;
        k = 0; seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            in_valid = (m_q.size() < 3);
            in_data  = 16'h0200 + 16'(k);
            if (in_valid) k++;
            tick();
            seen = (m_mode == 2) && (m_p == 4) && (m_q.size() == 3);
        end
        chk("t6_setup", 32'(seen), 1);
        chk("t6_setup_phase", 32'(phase), 4);
        in_valid = 0;
        #2;
        rst = 1;
        #1;
        chk("t6_phase", 32'(phase), 0);
        chk("t6_pclk", 32'(clk_out), 1);
        chk("t6_data", 32'(data_out), 0);
        chk("t6_strm", 32'(strm), 0);
        chk("t6_ready", 32'(in_ready), 1);
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        in_valid = 1; in_data = 16'hBEEF; tick();
        in_data = 16'hC0DE; tick();
        in_valid = 0;
        seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = (data_out != 16'h0);
        end
        chk("t6_first_after", 32'(data_out), 32'hBEEF);
        run(12);

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 0) enable = 0;
            else if (i % 300 == 20) enable = 1;
            else if ($urandom_range(0, 63) == 0) enable = ~enable;
            in_valid = ($urandom_range(0, 7) < ((i / 250) % 2 == 0 ? 5 : 1));
            in_data  = 16'($urandom);
            in_hs    = ($urandom_range(0, 7) == 0);
            in_vs    = ($urandom_range(0, 15) == 0);
            uf_clr   = ($urandom_range(0, 9) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
